// File: rtl/mux_pipe_stage_pkg.sv
// Shared definitions for the mux pipeline stage: FSM state type and select-width helper.
package mux_pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_pipe_stage_mux_nx1.sv
// Combinational N:1 WIDTH-bit selector; a select value >= N yields all-zeros.
module mux_nx1
    import mux_pipe_stage_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SELW  = sel_width(N)
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    output logic [WIDTH-1:0]   out_data
);

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(in_sel) == k) begin
                out_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_stage.sv
// N:1 selector feeding a 2-entry skid-buffered pipeline register with valid/ready and flush.
// Optional even-parity output enabled by defining MUX_PIPE_PARITY_EN.
module mux_pipe_stage
    import mux_pipe_stage_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_PIPE_PARITY_EN
    ,
    output logic               out_parity
`endif
);

`ifdef MUX_PIPE_PARITY_EN
    localparam int unsigned EW = WIDTH + 1;
`else
    localparam int unsigned EW = WIDTH;
`endif

    state_e           state_q;
    logic [EW-1:0]    main_q;
    logic [EW-1:0]    skid_q;
    logic [WIDTH-1:0] sel_word_d;
    logic [EW-1:0]    entry_d;
    logic             accept;

    mux_nx1 #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_mux (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_data (sel_word_d)
    );

    // Parity rides as the top bit of each stored entry so it moves with its word.
`ifdef MUX_PIPE_PARITY_EN
    assign entry_d    = {^sel_word_d, sel_word_d};
    assign out_parity = main_q[WIDTH];
`else
    assign entry_d    = sel_word_d;
`endif

    assign in_ready  = !rst && (state_q != ST_FULL);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q  <= entry_d;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !out_ready) begin
                        skid_q  <= entry_d;
                        state_q <= ST_FULL;
                    end else if (accept) begin
                        main_q  <= entry_d;
                    end else if (out_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        main_q  <= skid_q;
                        state_q <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Scoreboard bench for mux_pipe_stage (N=4 main instance, N=3 instance for out-of-range select).
module tb_mux_pipe_stage;

    logic         clk;
    logic         rst;
    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  in3_data;
    logic [1:0]   in3_sel;
    logic         in3_valid;
    logic         in3_ready;
    logic         flush3;
    logic [31:0]  out3_data;
    logic         out3_valid;
    logic         out3_ready;
`ifdef MUX_PIPE_PARITY_EN
    logic         out_parity;
    logic         out3_parity;
`endif

    mux_pipe_stage #(.N(4), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_PIPE_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    mux_pipe_stage #(.N(3), .WIDTH(32)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in3_data),
        .in_sel    (in3_sel),
        .in_valid  (in3_valid),
        .in_ready  (in3_ready),
        .flush     (flush3),
        .out_data  (out3_data),
        .out_valid (out3_valid),
        .out_ready (out3_ready)
`ifdef MUX_PIPE_PARITY_EN
        ,
        .out_parity(out3_parity)
`endif
    );

    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;
    localparam logic [31:0] WC = 32'hCCCC_0003;
    localparam logic [31:0] WD = 32'hDDDD_0004;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          pops     = 0;
    logic [31:0] q[$];
    logic [31:0] exp_cur;
    logic        acc_flag;
    logic [31:0] w[4];
    int unsigned s;
    int          tries;
    int          p0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    // One clock: record what the DUT accepts at the coming edge, then land 1ns past it.
    task automatic cycle();
        @(negedge clk);
        acc_flag = 1'b0;
        if (rst || flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            q.push_back(exp_cur);
            acc_flag = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] wd);
        in_data[31:0] = wd;
        in_sel        = 2'd0;
        exp_cur       = wd;
        in_valid      = 1'b1;
        cycle();
        in_valid      = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            pops++;
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %h expected no output", out_data);
            end else begin
                check("scoreboard", out_data, q.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        in_data    = {WD, WC, WB, WA};
        in_sel     = 2'd0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        exp_cur    = '0;
        in3_data   = {WC, WB, WA};
        in3_sel    = 2'd0;
        in3_valid  = 1'b1;
        flush3     = 1'b0;
        out3_ready = 1'b1;

        // Reset held two cycles with in_valid high
        cycle();
        cycle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out3_valid", 32'(out3_valid), 32'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        in3_valid = 1'b0;
        cycle();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Select and one-cycle latency
        in_sel   = 2'd2;
        exp_cur  = WC;
        in_valid = 1'b1;
        cycle();
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("sel2_data", out_data, WC);
        in_sel  = 2'd3;
        exp_cur = WD;
        cycle();
        in_valid = 1'b0;
        check("sel3_data", out_data, WD);
        cycle();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // N=3: out-of-range select returns zero
        in3_sel   = 2'd3;
        in3_valid = 1'b1;
        cycle();
        in3_valid = 1'b0;
        check("n3_sel3_valid", 32'(out3_valid), 32'd1);
        check("n3_sel3_zero", out3_data, 32'd0);
        in3_sel   = 2'd1;
        in3_valid = 1'b1;
        cycle();
        in3_valid = 1'b0;
        check("n3_sel1_data", out3_data, WB);

        // Back-pressure into the skid register
        out_ready = 1'b0;
        push_word(32'h11);
        push_word(32'h22);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", out_data, 32'h11);
        cycle();
        check("bp_head_stable", out_data, 32'h11);
        out_ready = 1'b1;
        cycle();
        check("bp_second", out_data, 32'h22);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        cycle();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Flush while FULL, then flush in ONE with a same-cycle accept
        out_ready = 1'b0;
        push_word(32'h31);
        push_word(32'h32);
        flush         = 1'b1;
        in_data[31:0] = 32'h55;
        exp_cur       = 32'h55;
        in_valid      = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_full_valid", 32'(out_valid), 32'd0);
        check("flush_full_ready", 32'(in_ready), 32'd1);
        push_word(32'h41);
        flush         = 1'b1;
        in_data[31:0] = 32'h66;
        exp_cur       = 32'h66;
        in_valid      = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_one_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        push_word(32'h77);
        check("after_flush_head", out_data, 32'h77);
        cycle();

        // Random streaming with random back-pressure
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 4; k++) w[k] = $urandom;
            s        = $urandom_range(0, 3);
            in_data  = {w[3], w[2], w[1], w[0]};
            in_sel   = 2'(s);
            exp_cur  = w[s];
            in_valid = 1'b1;
            tries    = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                cycle();
                tries++;
            end while (!acc_flag && tries < 50);
            check("stream_accept", 32'(acc_flag), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tries     = 0;
        while (q.size() > 0 && tries < 10) begin
            cycle();
            tries++;
        end
        check("stream_drained", 32'(q.size()), 32'd0);

        // Full throughput with out_ready held high
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            w[0]     = 32'h1000_0000 + 32'(i);
            in_data  = {WD, WC, WB, w[0]};
            in_sel   = 2'd0;
            exp_cur  = w[0];
            in_valid = 1'b1;
            cycle();
            check("thru_accept", 32'(acc_flag), 32'd1);
        end
        in_valid = 1'b0;
        cycle();
        check("thru_pops", 32'(pops - p0), 32'd20);

`ifdef MUX_PIPE_PARITY_EN
        push_word(32'h0000_0007);
        check("parity_7", 32'(out_parity), 32'd1);
        push_word(32'h0000_0003);
        check("parity_3", 32'(out_parity), 32'd0);
        cycle();
`endif

        cycle();
        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
